// File: rtl/r5p_mouse_retire_tracer.sv
// r5p_mouse_retire_tracer: builds one retirement record per committed instruction
// from TCB bus snooping and queues the records in a small FIFO with valid/ready output.
module r5p_mouse_retire_tracer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pha,
  input  logic        tcb_vld,
  input  logic        tcb_rdy,
  input  logic [31:0] tcb_adr,
  input  logic [1:0]  tcb_siz,
  input  logic [31:0] tcb_wdt,
  input  logic [31:0] tcb_rdt,
  input  logic        trc_flush,
  output logic        trc_vld,
  input  logic        trc_rdy,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_ins,
  output logic        trc_wbe,
  output logic [4:0]  trc_rd,
  output logic [31:0] trc_wbd,
  output logic        trc_ldv,
  output logic [31:0] trc_lda,
  output logic        trc_stv,
  output logic [31:0] trc_sta,
  output logic [1:0]  trc_sts,
  output logic [31:0] trc_std,
  output logic        trc_ovf,
  output logic [31:0] trc_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] PH_IF = 3'd0, PH_MLD = 3'd1, PH_MST = 3'd2, PH_WB = 3'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        wbe;
    logic [4:0]  rd;
    logic [31:0] wbd;
    logic        ldv;
    logic [31:0] lda;
    logic        stv;
    logic [31:0] sta;
    logic [1:0]  sts;
    logic [31:0] std;
  } rec_t;
  rec_t        orec_q, orec_d, crec;
  rec_t        mem_q [FIFO_DEPTH];
  rec_t        mem_d [FIFO_DEPTH];
  rec_t        head;
  logic        open_q, open_d, ins_pend_q, ins_pend_d, ovf_q, ovf_d;
  logic [31:0] cnt_q, cnt_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        trn, if_trn, commit, empty, full, push, pop;
  always_comb begin
    trn        = tcb_vld & tcb_rdy;
    if_trn     = trn & (pha == PH_IF);
    commit     = open_q & (if_trn | trc_flush);
    empty      = wp_q == rp_q;
    full       = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop        = !empty & trc_rdy;
    push       = commit & (!full | pop);
    // instruction word arrives one cycle after its fetch; bypass it into a same-cycle commit
    crec       = orec_q;
    crec.ins   = ins_pend_q ? tcb_rdt : orec_q.ins;
    orec_d     = crec;
    open_d     = if_trn ? 1'b1 : (commit ? 1'b0 : open_q);
    ins_pend_d = if_trn;
    if (if_trn) begin
      orec_d.pc  = tcb_adr;
      orec_d.wbe = 1'b0;
      orec_d.ldv = 1'b0;
      orec_d.stv = 1'b0;
    end
    if (trn && pha == PH_WB) begin
      orec_d.wbe = 1'b1;
      orec_d.rd  = tcb_adr[6:2];
      orec_d.wbd = tcb_wdt;
    end
    if (trn && pha == PH_MLD) begin
      orec_d.ldv = 1'b1;
      orec_d.lda = tcb_adr;
    end
    if (trn && pha == PH_MST) begin
      orec_d.stv = 1'b1;
      orec_d.sta = tcb_adr;
      orec_d.sts = tcb_siz;
      orec_d.std = tcb_siz == 2'd0 ? {24'd0, tcb_wdt[7:0]} :
                   tcb_siz == 2'd1 ? {16'd0, tcb_wdt[15:0]} : tcb_wdt;
    end
    cnt_d = commit ? cnt_q + 32'd1 : cnt_q;
    ovf_d = ovf_q | (commit & !push);
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    mem_d = mem_q;
    if (push) mem_d[wp_q[AW-1:0]] = crec;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orec_q     <= '0;
      open_q     <= 1'b0;
      ins_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      mem_q      <= '{default: '0};
    end else begin
      orec_q     <= orec_d;
      open_q     <= open_d;
      ins_pend_q <= ins_pend_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      mem_q      <= mem_d;
    end
  end
  assign head    = mem_q[rp_q[AW-1:0]];
  assign trc_vld = !empty;
  assign trc_pc  = head.pc;
  assign trc_ins = head.ins;
  assign trc_wbe = head.wbe;
  assign trc_rd  = head.rd;
  assign trc_wbd = head.wbd;
  assign trc_ldv = head.ldv;
  assign trc_lda = head.lda;
  assign trc_stv = head.stv;
  assign trc_sta = head.sta;
  assign trc_sts = head.sts;
  assign trc_std = head.std;
  assign trc_ovf = ovf_q;
  assign trc_cnt = cnt_q;
endmodule
